// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM: fetch / decode / execute / memory / write-back,
// with a memory-wait timeout and a sticky trap state for illegal opcodes or stalls.
module mc_control_fsm #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       branch,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic [2:0] state
);

    localparam int CW = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t        cur;
    logic [6:0]    op_q;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          timeout;
    logic          op_legal;

    assign waiting  = ((cur == S_FETCH) || (cur == S_MEM)) && !mem_ready;
    assign timeout  = (WAIT_MAX != 0) && waiting && (wait_cnt == CW'(WAIT_MAX));
    assign op_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LW) ||
                      (opcode == OP_SW) || (opcode == OP_BEQ);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            case (cur)
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                          else if (timeout) cur <= S_TRAP;
                S_DECODE: begin
                    op_q <= opcode;
                    cur  <= op_legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    if ((op_q == OP_LW) || (op_q == OP_SW)) cur <= S_MEM;
                    else if (op_q == OP_BEQ)                cur <= S_FETCH;
                    else                                    cur <= S_WB;
                end
                S_MEM:    if (mem_ready) cur <= (op_q == OP_LW) ? S_WB : S_FETCH;
                          else if (timeout) cur <= S_TRAP;
                S_WB:     cur <= S_FETCH;
                default:  cur <= S_TRAP;   // TRAP holds; unused encodings 6-7 fall in here
            endcase

            // Staying in FETCH/MEM only happens while waiting without timeout; anything else is a state change.
            if (waiting && !timeout) begin
                if (wait_cnt != {CW{1'b1}}) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        state      = 3'd0;
        if (!rst) begin
            state = cur;
            case (cur)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_EXEC: begin
                    if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                        alu_src = 1'b1;
                    end else if (op_q == OP_BEQ) begin
                        alu_op     = 2'b01;
                        branch     = 1'b1;
                        pc_src     = 1'b1;
                        pc_write   = zero;
                        instr_done = 1'b1;
                    end else begin
                        alu_src = (op_q == OP_I);
                        alu_op  = 2'b10;
                    end
                end
                S_MEM: begin
                    iord       = 1'b1;
                    alu_src    = 1'b1;
                    mem_read   = (op_q == OP_LW);
                    mem_write  = (op_q == OP_SW);
                    instr_done = (op_q == OP_SW) && mem_ready;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    mem_to_reg = (op_q == OP_LW);
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (WAIT_MAX=4): instruction flows, waits, timeout,
// illegal opcode trap and reset behaviour, checked with immediate assertions.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write;
    logic       reg_write, mem_to_reg, alu_src, branch, instr_done, illegal;
    logic [1:0] alu_op;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    mc_control_fsm #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch), .alu_op(alu_op),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Field order: pc_write pc_src ir_write iord mem_read mem_write reg_write mem_to_reg alu_src branch alu_op instr_done illegal
    logic [13:0] obs;
    assign obs = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                  mem_to_reg, alu_src, branch, alu_op, instr_done, illegal};

    localparam logic [13:0] NONE     = 14'b0;
    localparam logic [13:0] F_WAIT   = 14'b0_0_0_0_1_0_0_0_0_0_00_0_0;
    localparam logic [13:0] F_RDY    = 14'b1_0_1_0_1_0_0_0_0_0_00_0_0;
    localparam logic [13:0] EX_R     = 14'b0_0_0_0_0_0_0_0_0_0_10_0_0;
    localparam logic [13:0] EX_I     = 14'b0_0_0_0_0_0_0_0_1_0_10_0_0;
    localparam logic [13:0] EX_LS    = 14'b0_0_0_0_0_0_0_0_1_0_00_0_0;
    localparam logic [13:0] EX_BEQ_T = 14'b1_1_0_0_0_0_0_0_0_1_01_1_0;
    localparam logic [13:0] EX_BEQ_N = 14'b0_1_0_0_0_0_0_0_0_1_01_1_0;
    localparam logic [13:0] MEM_LW   = 14'b0_0_0_1_1_0_0_0_1_0_00_0_0;
    localparam logic [13:0] MEM_SW   = 14'b0_0_0_1_0_1_0_0_1_0_00_0_0;
    localparam logic [13:0] MEM_SW_D = 14'b0_0_0_1_0_1_0_0_1_0_00_1_0;
    localparam logic [13:0] WB_LW    = 14'b0_0_0_0_0_0_1_1_0_0_00_1_0;
    localparam logic [13:0] WB_R     = 14'b0_0_0_0_0_0_1_0_0_0_00_1_0;
    localparam logic [13:0] TRAP_O   = 14'b0_0_0_0_0_0_0_0_0_0_00_0_1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Apply inputs mid-cycle, check state and outputs, then advance one clock.
    task automatic step(input string tag, input logic [6:0] op, input logic z, input logic mr,
                        input logic [2:0] es, input logic [13:0] eo);
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        #1;
        chk({tag, "/state"}, 14'(state), 14'(es));
        chk(tag, obs, eo);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rst_cyc(input string tag);
        rst       = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b1;
        #1;
        chk({tag, "/state"}, 14'(state), 14'd0);
        chk(tag, obs, NONE);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_cyc("reset");
        rst = 1'b0;

        // R-type; opcode input is scrambled after DECODE to prove EXEC uses the latched copy
        step("r_fetch", OP_R,  0, 1, 3'd0, F_RDY);
        step("r_dec",   OP_R,  0, 1, 3'd1, NONE);
        step("r_exec",  7'h00, 0, 1, 3'd2, EX_R);
        step("r_wb",    7'h00, 0, 1, 3'd4, WB_R);

        step("i_fetch", OP_I, 0, 1, 3'd0, F_RDY);
        step("i_dec",   OP_I, 0, 1, 3'd1, NONE);
        step("i_exec",  OP_I, 0, 1, 3'd2, EX_I);
        step("i_wb",    OP_I, 0, 1, 3'd4, WB_R);

        // LW with three MEM wait cycles
        step("lw_fetch", OP_LW, 0, 1, 3'd0, F_RDY);
        step("lw_dec",   OP_LW, 0, 1, 3'd1, NONE);
        step("lw_exec",  OP_LW, 0, 1, 3'd2, EX_LS);
        for (int i = 0; i < 3; i++) step("lw_mem_wait", OP_LW, 0, 0, 3'd3, MEM_LW);
        step("lw_mem_rdy", OP_LW, 0, 1, 3'd3, MEM_LW);
        step("lw_wb",      OP_LW, 0, 1, 3'd4, WB_LW);

        step("sw_fetch", OP_SW, 0, 1, 3'd0, F_RDY);
        step("sw_dec",   OP_SW, 0, 1, 3'd1, NONE);
        step("sw_exec",  OP_SW, 0, 1, 3'd2, EX_LS);
        step("sw_mem",   OP_SW, 0, 1, 3'd3, MEM_SW_D);

        step("beq_t_fetch", OP_BEQ, 1, 1, 3'd0, F_RDY);
        step("beq_t_dec",   OP_BEQ, 1, 1, 3'd1, NONE);
        step("beq_t_exec",  OP_BEQ, 1, 1, 3'd2, EX_BEQ_T);
        step("beq_n_fetch", OP_BEQ, 0, 1, 3'd0, F_RDY);
        step("beq_n_dec",   OP_BEQ, 0, 1, 3'd1, NONE);
        step("beq_n_exec",  OP_BEQ, 0, 1, 3'd2, EX_BEQ_N);

        // Fetch timeout: WAIT_MAX=4 traps after the fifth stalled FETCH cycle
        for (int i = 0; i < 5; i++) step("to_fetch_wait", OP_R, 0, 0, 3'd0, F_WAIT);
        for (int i = 0; i < 3; i++) step("to_trap", OP_R, 0, i[0], 3'd5, TRAP_O);
        rst_cyc("to_rst");
        rst = 1'b0;

        // Ready arriving in the timeout cycle wins; then an illegal opcode traps
        for (int i = 0; i < 4; i++) step("edge_fetch_wait", OP_BAD, 0, 0, 3'd0, F_WAIT);
        step("edge_fetch_rdy", OP_BAD, 0, 1, 3'd0, F_RDY);
        step("bad_dec",        OP_BAD, 0, 1, 3'd1, NONE);
        for (int i = 0; i < 20; i++) step("bad_trap_hold", OP_BAD, i[0], i[1], 3'd5, TRAP_O);
        rst_cyc("bad_rst");
        rst = 1'b0;
        step("bad_after_rst", OP_R, 0, 0, 3'd0, F_WAIT);

        // SW interrupted by reset during the MEM wait
        step("swr_fetch", OP_SW, 0, 1, 3'd0, F_RDY);
        step("swr_dec",   OP_SW, 0, 1, 3'd1, NONE);
        step("swr_exec",  OP_SW, 0, 1, 3'd2, EX_LS);
        step("swr_mem_w", OP_SW, 0, 0, 3'd3, MEM_SW);
        step("swr_mem_w", OP_SW, 0, 0, 3'd3, MEM_SW);
        rst_cyc("swr_rst");
        rst_cyc("swr_rst");
        rst = 1'b0;
        step("swr_fetch_w", OP_SW, 0, 0, 3'd0, F_WAIT);
        step("swr_fetch_w", OP_SW, 0, 0, 3'd0, F_WAIT);
        step("swr_fetch_r", OP_R,  0, 1, 3'd0, F_RDY);
        step("swr_r_dec",   OP_R,  0, 1, 3'd1, NONE);
        step("swr_r_exec",  OP_R,  0, 1, 3'd2, EX_R);
        step("swr_r_wb",    OP_R,  0, 1, 3'd4, WB_R);
        step("swr_end",     OP_R,  0, 0, 3'd0, F_WAIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
